uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Parallel-in, serial-out UART transmitter.
- Accepts one 8-bit word per handshake and emits one frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sends one bit per clock cycle. Any baud-rate clock enable or divided clock is generated upstream, so CLK is the bit clock.
- Sits between the system-side producer and the serial line; BUSY provides back-pressure.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. P_DATA width follows it; the bit counter is sized to hold DATA_WIDTH-1.

Ports:
- CLK  input  1  bit clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous, active-low (sampled on the CLK rising edge while 0).
- PAR_EN  input  1  1 = insert a parity bit after the data bits.
- PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
- P_DATA  input  DATA_WIDTH  word to transmit.
- DATA_VALID  input  1  P_DATA is valid; request to start a frame.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=0 at a rising edge):
  - FSM goes to IDLE; TX_OUT=1; BUSY=0.
  - Shift register, bit counter and latched configuration are cleared.
  - A reset mid-frame aborts the frame immediately; the line returns high on that edge.
- Outputs are registered; no combinational path from inputs to TX_OUT or BUSY.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - If DATA_VALID=1 at an edge: latch P_DATA, PAR_EN and PAR_TYP, compute parity, then go to START.
  - Otherwise stay in IDLE.
- START: TX_OUT=0, BUSY=1 for one cycle, then DATA with bit counter 0.
- DATA:
  - TX_OUT = latched data[counter], starting at bit 0 (LSB first), one bit per cycle.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = parity bit for one cycle, then STOP.
  - Even (PAR_TYP=0): bit = XOR of the data bits.
  - Odd (PAR_TYP=1): bit = inverted XOR of the data bits.
- STOP: TX_OUT=1 for one cycle, BUSY=1, then IDLE.
- Latency and frame length:
  - DATA_VALID sampled at edge k → start bit on TX_OUT from edge k until edge k+1.
  - Data bit i is driven during cycle k+1+i.
  - BUSY rises at edge k and stays high for 10 cycles (PAR_EN=0) or 11 cycles (PAR_EN=1).
  - BUSY falls on the edge that returns the FSM to IDLE.
- Handshake:
  - DATA_VALID is honoured only in IDLE. While BUSY=1 it is ignored; no queuing.
  - Changes to P_DATA, PAR_EN or PAR_TYP during a frame do not affect that frame.
  - Back-to-back frames: the next frame starts no earlier than one IDLE cycle after STOP, i.e. at least one idle-high bit between frames.
- DATA_VALID held high continuously: a new frame starts at each IDLE visit. The period is frame length + 1 cycles.

Test Plan:
- Reset: hold RST=0 for 2 cycles with DATA_VALID=1 → TX_OUT=1 and BUSY=0 throughout. After release, DATA_VALID=1 starts a frame on the next edge.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, single-cycle DATA_VALID → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0). BUSY high for exactly 11 cycles, then TX_OUT=1, BUSY=0.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 → parity bit 1. Second: P_DATA=0x07, PAR_TYP=1 → parity bit 0 (three ones).
- P_DATA=0x00, PAR_EN=0 → 0, eight 0s, 1. BUSY high for exactly 10 cycles.
- Mid-frame interference: after the start bit, change P_DATA to 0xFF and pulse DATA_VALID → the original frame is unchanged and no extra frame starts. DATA_VALID held high throughout → consecutive frames separated by exactly one idle-high cycle.
- Reset during DATA state (e.g. 4th data bit) → on the reset edge TX_OUT=1 and BUSY=0. A new DATA_VALID afterwards transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Producer-side handshake and serial-line signals for the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one bit per i_clk, frame = start, data LSB first,
// optional parity, stop. TX/BUSY are registered and reflect the state
// being entered, so the start bit appears on the edge that accepts the word.
//
// state  | meaning
// IDLE   | line high, not busy, waiting for data_valid
// START  | driving the start bit (0)
// DATA   | driving latched data bit r_cnt
// PARITY | driving the precomputed parity bit
// STOP   | driving the stop bit (1)
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  uart_tx_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;

  // State, counter, latched frame configuration and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (r_state == S_IDLE && bus.data_valid) begin
        r_data    <= bus.p_data;
        r_par_en  <= bus.par_en;
        r_par_bit <= (^bus.p_data) ^ bus.par_typ;
      end
    end
  end

  // Next-state and bit-counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE:   if (bus.data_valid) w_state_nxt = S_START;
      S_START: begin
        w_state_nxt = S_DATA;
        w_cnt_nxt   = '0;
      end
      S_DATA: begin
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PARITY: w_state_nxt = S_STOP;
      S_STOP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Line level and busy for the state being entered on this edge.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    unique case (w_state_nxt)
      S_IDLE:   w_busy_nxt = 1'b0;
      S_START:  w_tx_nxt   = 1'b0;
      S_DATA:   w_tx_nxt   = r_data[w_cnt_nxt];
      S_PARITY: w_tx_nxt   = r_par_bit;
      default:  w_tx_nxt   = 1'b1;
    endcase
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line sequences are written out by hand
// as strings, one character per bit cycle, starting with the start bit.
module tb_uart_tx;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  uart_tx_if #(.DATA_WIDTH(8)) u_if ();

  uart_tx #(.DATA_WIDTH(8)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word and checks every line cycle plus the idle cycle after it.
  // interfere: disturb inputs and pulse data_valid while the frame is busy.
  // keep_valid: leave data_valid high after the frame is accepted.
  task automatic frame(input string tag, input logic [7:0] d, input logic pe,
                       input logic pt, input string seq, input bit interfere,
                       input bit keep_valid);
    u_if.p_data     = d;
    u_if.par_en     = pe;
    u_if.par_typ    = pt;
    u_if.data_valid = 1'b1;
    for (int i = 0; i < seq.len(); i++) begin
      tick();
      if (i == 0 && !keep_valid) u_if.data_valid = 1'b0;
      if (interfere && i == 1) begin
        u_if.p_data     = 8'hFF;
        u_if.par_typ    = ~pt;
        u_if.par_en     = ~pe;
        u_if.data_valid = 1'b1;
      end
      if (interfere && i == 2) u_if.data_valid = 1'b0;
      check($sformatf("%s tx[%0d]", tag, i), u_if.tx_out, seq[i] == 8'h31);
      check($sformatf("%s busy[%0d]", tag, i), u_if.busy, 1'b1);
    end
    tick();
    check({tag, " idle tx"}, u_if.tx_out, 1'b1);
    check({tag, " idle busy"}, u_if.busy, 1'b0);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    u_if.p_data     = 8'h3C;
    u_if.par_en     = 1'b0;
    u_if.par_typ    = 1'b0;
    u_if.data_valid = 1'b1;

    // Reset held with data_valid asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset tx", u_if.tx_out, 1'b1);
      check("reset busy", u_if.busy, 1'b0);
    end
    rst_n = 1'b1;

    // First edge after release starts a frame.
    frame("3C np", 8'h3C, 1'b0, 1'b0, "0001111001", 1'b0, 1'b0);
    frame("A5 even", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b0, 1'b0);
    frame("A5 odd", 8'hA5, 1'b1, 1'b1, "01010010111", 1'b0, 1'b0);
    frame("07 odd", 8'h07, 1'b1, 1'b1, "01110000001", 1'b0, 1'b0);
    frame("00 np", 8'h00, 1'b0, 1'b0, "0000000001", 1'b0, 1'b0);

    // Inputs disturbed mid-frame: frame unchanged, no extra frame afterwards.
    frame("A5 interf", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b1, 1'b0);
    tick();
    check("no extra tx", u_if.tx_out, 1'b1);
    check("no extra busy", u_if.busy, 1'b0);

    // Valid held high: exactly one idle-high cycle between frames.
    frame("held 1", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b0, 1'b1);
    frame("held 2", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b0, 1'b0);

    // Reset while the 4th data bit (a 0) is on the line.
    u_if.p_data     = 8'h52;
    u_if.par_en     = 1'b0;
    u_if.par_typ    = 1'b0;
    u_if.data_valid = 1'b1;
    tick();
    u_if.data_valid = 1'b0;
    check("abort start", u_if.tx_out, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("abort bit3", u_if.tx_out, 1'b0);
    check("abort busy", u_if.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("abort rst tx", u_if.tx_out, 1'b1);
    check("abort rst busy", u_if.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post abort tx", u_if.tx_out, 1'b1);
    check("post abort busy", u_if.busy, 1'b0);
    frame("5A even", 8'h5A, 1'b1, 1'b0, "00101101001", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
